// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// function codes and the ALU / extender / next-PC select values.
package multi_cycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    IC_RTYPE, IC_LW, IC_SW, IC_IMM, IC_BEQ, IC_JUMP, IC_ILL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  localparam logic [1:0] EXT_ZERO    = 2'd0;
  localparam logic [1:0] EXT_SIGNED  = 2'd1;
  localparam logic [1:0] EXT_HIGHPOS = 2'd2;

  localparam logic [1:0] NPC_ALU    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;

  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_4     = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and status in, strobes/selects out.
interface multi_cycle_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] WDSel;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic [1:0] EXTOp;
  logic [1:0] NPCOp;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, WDSel,
           ALUSrcA, ALUSrcB, ALUOp, EXTOp, NPCOp, illegal, state
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, WDSel,
           ALUSrcA, ALUSrcB, ALUOp, EXTOp, NPCOp, illegal, state
  );
endinterface

// File: rtl/multi_cycle_ctrl_main_decoder.sv
// Combinational decode of Op/Funct into instruction class, ALU ops and
// immediate-extension mode.
module main_decoder
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0] Op_i,
  input  logic [5:0] Funct_i,
  output iclass_t    iclass_o,
  output logic [3:0] alu_r_o,
  output logic [3:0] alu_i_o,
  output logic [1:0] ext_o,
  output logic       illegal_op_o,
  output logic       funct_bad_o
);

  always_comb begin
    iclass_o = IC_ILL;
    alu_i_o  = ALU_ADD;
    ext_o    = EXT_SIGNED;
    case (Op_i)
      OP_RTYPE:     iclass_o = IC_RTYPE;
      OP_LW:        iclass_o = IC_LW;
      OP_SW:        iclass_o = IC_SW;
      OP_ADDI:      iclass_o = IC_IMM;
      OP_ORI: begin
        iclass_o = IC_IMM;
        alu_i_o  = ALU_OR;
        ext_o    = EXT_ZERO;
      end
      // lui = rs($0) | (imm << 16), the shift comes from the extender
      OP_LUI: begin
        iclass_o = IC_IMM;
        alu_i_o  = ALU_OR;
        ext_o    = EXT_HIGHPOS;
      end
      OP_BEQ:       iclass_o = IC_BEQ;
      OP_J, OP_JAL: iclass_o = IC_JUMP;
      default:      iclass_o = IC_ILL;
    endcase
  end

  always_comb begin
    alu_r_o = ALU_NOP;
    case (Funct_i)
      FN_ADD:  alu_r_o = ALU_ADD;
      FN_SUB:  alu_r_o = ALU_SUB;
      FN_AND:  alu_r_o = ALU_AND;
      FN_OR:   alu_r_o = ALU_OR;
      FN_SLT:  alu_r_o = ALU_SLT;
      default: alu_r_o = ALU_NOP;
    endcase
  end

  assign illegal_op_o = (iclass_o == IC_ILL);
  assign funct_bad_o  = (alu_r_o == ALU_NOP);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multicycle MIPS control FSM: sequences one instruction over 3-5 cycles,
// stretching memory states until mem_ready.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter bit RESET_PC_WRITE = 1'b0
) (
  input logic                clk,
  input logic                rstn,
  multi_cycle_ctrl_if.master bus
);

  state_t     state_q, state_d;
  logic       boot_q;
  iclass_t    iclass;
  logic [3:0] alu_r, alu_i, aop;
  logic [1:0] ext, rdst, wds, asb, npc;
  logic       illegal_op, funct_bad;
  logic       pcw, irw, iord, mrd, mwr, rw, asa, ill;

  main_decoder u_dec (
    .Op_i         (bus.Op),
    .Funct_i      (bus.Funct),
    .iclass_o     (iclass),
    .alu_r_o      (alu_r),
    .alu_i_o      (alu_i),
    .ext_o        (ext),
    .illegal_op_o (illegal_op),
    .funct_bad_o  (funct_bad)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_FETCH;
      boot_q  <= RESET_PC_WRITE;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    pcw  = 1'b0;  irw = 1'b0;  iord = 1'b0;  mrd = 1'b0;
    mwr  = 1'b0;  rw  = 1'b0;  asa  = 1'b0;  ill = 1'b0;
    rdst = RDST_RT;  wds = WD_ALU;  asb = SRCB_RT;  npc = NPC_ALU;
    aop  = ALU_NOP;
    case (state_q)
      S_FETCH: begin
        mrd = 1'b1;
        asb = SRCB_4;
        aop = ALU_ADD;
        if (bus.mem_ready) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        asb = SRCB_IMMSH;
        aop = ALU_ADD;
        case (iclass)
          IC_LW, IC_SW: state_d = S_MEMADR;
          IC_RTYPE:     state_d = S_EXEC_R;
          IC_IMM:       state_d = S_EXEC_I;
          IC_BEQ:       state_d = S_BRANCH;
          IC_JUMP:      state_d = S_JUMP;
          default: begin
            ill     = illegal_op;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        asa     = 1'b1;
        asb     = SRCB_IMM;
        aop     = ALU_ADD;
        state_d = (iclass == IC_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mrd  = 1'b1;
        iord = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rw      = 1'b1;
        rdst    = RDST_RT;
        wds     = WD_MDR;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        mwr  = 1'b1;
        iord = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        asa = 1'b1;
        asb = SRCB_RT;
        aop = alu_r;
        if (funct_bad) begin
          ill     = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_EXEC_I: begin
        asa     = 1'b1;
        asb     = SRCB_IMM;
        aop     = alu_i;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw      = 1'b1;
        wds     = WD_ALU;
        rdst    = (iclass == IC_RTYPE) ? RDST_RD : RDST_RT;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        asa     = 1'b1;
        asb     = SRCB_RT;
        aop     = ALU_SUB;
        pcw     = bus.Zero;
        npc     = NPC_BRANCH;
        state_d = S_FETCH;
      end
      // PC already holds PC+4 here, which is the jal link value
      S_JUMP: begin
        pcw = 1'b1;
        npc = NPC_JUMP;
        if (bus.Op == OP_JAL) begin
          rw   = 1'b1;
          rdst = RDST_RA;
          wds  = WD_PC;
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates outputs combinationally so an abort kills strobes at once
  assign bus.PCWrite  = rstn & (pcw | boot_q);
  assign bus.IRWrite  = rstn & irw;
  assign bus.IorD     = rstn & iord;
  assign bus.MemRead  = ~rstn | mrd;
  assign bus.MemWrite = rstn & mwr;
  assign bus.RegWrite = rstn & rw;
  assign bus.RegDst   = rstn ? rdst : 2'd0;
  assign bus.WDSel    = rstn ? wds  : 2'd0;
  assign bus.ALUSrcA  = rstn & asa;
  assign bus.ALUSrcB  = rstn ? asb  : 2'd0;
  assign bus.ALUOp    = rstn ? aop  : 4'd0;
  assign bus.EXTOp    = rstn ? ext  : 2'd0;
  assign bus.NPCOp    = rstn ? npc  : 2'd0;
  assign bus.illegal  = rstn & ill;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Random instruction stream checked every cycle against a per-instruction
// phase-list model, plus directed CPI / strobe / abort checks.
module tb_multi_cycle_ctrl;
  import multi_cycle_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, iord, mrd, mwr, rw;
    logic [1:0] rdst, wds;
    logic       asa;
    logic [1:0] asb;
    logic [3:0] aop;
    logic [1:0] ext, npc;
    logic       ill;
  } obs_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  multi_cycle_ctrl_if ifc ();
  multi_cycle_ctrl #(.RESET_PC_WRITE(1'b0)) dut (.clk(clk), .rstn(rstn), .bus(ifc));

  int total = 0;
  int bad   = 0;
  state_t seq_st[8];
  bit     seq_wt[8];
  int     nph;
  obs_t   act_log[8];
  int     cyc, rw_cnt, mw_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st = ifc.state;     o.pcw = ifc.PCWrite;  o.irw = ifc.IRWrite;
    o.iord = ifc.IorD;    o.mrd = ifc.MemRead;  o.mwr = ifc.MemWrite;
    o.rw = ifc.RegWrite;  o.rdst = ifc.RegDst;  o.wds = ifc.WDSel;
    o.asa = ifc.ALUSrcA;  o.asb = ifc.ALUSrcB;  o.aop = ifc.ALUOp;
    o.ext = ifc.EXTOp;    o.npc = ifc.NPCOp;    o.ill = ifc.illegal;
    return o;
  endfunction

  function automatic logic [3:0] fn_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return ALU_ADD;
      6'h22: return ALU_SUB;
      6'h24: return ALU_AND;
      6'h25: return ALU_OR;
      6'h2A: return ALU_SLT;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    case (op)
      6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0D, 6'h0F, 6'h02, 6'h03: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Outputs each phase must show, straight from the per-state output table
  function automatic obs_t expect_obs(input state_t s, input logic [5:0] op,
                                      input logic [5:0] fn, input logic z, input logic mr);
    obs_t o = '0;
    o.st  = s;
    o.ext = (op == 6'h0D) ? EXT_ZERO : (op == 6'h0F) ? EXT_HIGHPOS : EXT_SIGNED;
    case (s)
      S_FETCH:  begin o.mrd = 1; o.asb = 2'd1; o.aop = ALU_ADD; o.pcw = mr; o.irw = mr; end
      S_DECODE: begin o.asb = 2'd3; o.aop = ALU_ADD; o.ill = !op_known(op); end
      S_MEMADR: begin o.asa = 1; o.asb = 2'd2; o.aop = ALU_ADD; end
      S_MEMRD:  begin o.mrd = 1; o.iord = 1; end
      S_MEMWB:  begin o.rw = 1; o.rdst = 2'd0; o.wds = 2'd1; end
      S_MEMWR:  begin o.mwr = 1; o.iord = 1; end
      S_EXEC_R: begin o.asa = 1; o.asb = 2'd0; o.aop = fn_alu(fn); o.ill = (fn_alu(fn) == ALU_NOP); end
      S_EXEC_I: begin o.asa = 1; o.asb = 2'd2; o.aop = (op == 6'h08) ? ALU_ADD : ALU_OR; end
      S_ALUWB:  begin o.rw = 1; o.wds = 2'd0; o.rdst = (op == 6'h00) ? 2'd1 : 2'd0; end
      S_BRANCH: begin o.asa = 1; o.asb = 2'd0; o.aop = ALU_SUB; o.pcw = z; o.npc = 2'd1; end
      S_JUMP: begin
        o.pcw = 1; o.npc = 2'd2;
        if (op == 6'h03) begin o.rw = 1; o.rdst = 2'd2; o.wds = 2'd2; end
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(input state_t s, input bit w);
    seq_st[nph] = s;
    seq_wt[nph] = w;
    nph++;
  endtask

  // Phase list an instruction walks through; wait-phases stretch on mem_ready
  task automatic build(input logic [5:0] op, input logic [5:0] fn);
    nph = 0;
    push(S_FETCH, 1);
    push(S_DECODE, 0);
    case (op)
      6'h00: begin push(S_EXEC_R, 0); if (fn_alu(fn) != ALU_NOP) push(S_ALUWB, 0); end
      6'h23: begin push(S_MEMADR, 0); push(S_MEMRD, 1); push(S_MEMWB, 0); end
      6'h2B: begin push(S_MEMADR, 0); push(S_MEMWR, 1); end
      6'h08, 6'h0D, 6'h0F: begin push(S_EXEC_I, 0); push(S_ALUWB, 0); end
      6'h04: push(S_BRANCH, 0);
      6'h02, 6'h03: push(S_JUMP, 0);
      default: ;
    endcase
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw, input string nm);
    int p = 0;
    int w = 0;
    logic mr;
    obs_t e, a;
    build(op, fn);
    ifc.Op = op; ifc.Funct = fn; ifc.Zero = z;
    cyc = 0; rw_cnt = 0; mw_cnt = 0;
    while (p < nph) begin
      if (seq_wt[p]) mr = (w < ((seq_st[p] == S_FETCH) ? fw : mw)) ? 1'b0 : 1'b1;
      else           mr = 1'($urandom_range(0, 1));
      ifc.mem_ready = mr;
      e = expect_obs(seq_st[p], op, fn, z, mr);
      @(negedge clk);
      a = sample();
      chk(nm, 32'(a), 32'(e));
      act_log[p] = a;
      cyc++;
      rw_cnt += int'(a.rw);
      mw_cnt += int'(a.mwr);
      @(posedge clk); #1;
      if (!seq_wt[p] || mr) begin p++; w = 0; end
      else w++;
    end
  endtask

  initial begin
    obs_t rv, a;
    logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0D, 6'h0F, 6'h02, 6'h03, 6'h3F, 6'h11};
    logic [5:0] fns [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};

    ifc.Op = 6'h0D; ifc.Funct = 6'h00; ifc.Zero = 1'b0; ifc.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rv = '0; rv.mrd = 1'b1;
    chk("reset_vec", 32'(sample()), 32'(rv));
    @(posedge clk); #1 rstn = 1'b1;

    run_instr(6'h00, 6'h20, 1'b0, 0, 0, "add");
    chk("add_cpi", cyc, 4);
    chk("add_wb_rw", 32'(act_log[3].rw), 1);
    chk("add_wb_rdst", 32'(act_log[3].rdst), 1);

    run_instr(6'h23, 6'h00, 1'b0, 0, 2, "lw_wait");
    chk("lw_wait_cpi", cyc, 7);
    chk("lw_rw_pulses", rw_cnt, 1);
    chk("lw_wb_wdsel", 32'(act_log[4].wds), 1);

    run_instr(6'h23, 6'h00, 1'b0, 0, 0, "lw");
    chk("lw_cpi", cyc, 5);
    run_instr(6'h2B, 6'h00, 1'b0, 0, 0, "sw");
    chk("sw_cpi", cyc, 4);

    run_instr(6'h04, 6'h00, 1'b1, 0, 0, "beq_t");
    chk("beq_cpi", cyc, 3);
    chk("beq_t_pcw", 32'(act_log[2].pcw), 1);
    chk("beq_t_npc", 32'(act_log[2].npc), 1);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, "beq_n");
    chk("beq_n_pcw", 32'(act_log[2].pcw), 0);

    run_instr(6'h0D, 6'h00, 1'b0, 0, 0, "ori");
    chk("ori_ext", 32'(act_log[2].ext), 32'(EXT_ZERO));
    run_instr(6'h0F, 6'h00, 1'b0, 0, 0, "lui");
    chk("lui_ext", 32'(act_log[2].ext), 32'(EXT_HIGHPOS));
    chk("lui_aop", 32'(act_log[2].aop), 32'(ALU_OR));
    run_instr(6'h08, 6'h00, 1'b0, 0, 0, "addi");
    chk("addi_ext", 32'(act_log[2].ext), 32'(EXT_SIGNED));
    chk("addi_cpi", cyc, 4);

    run_instr(6'h03, 6'h00, 1'b0, 0, 0, "jal");
    chk("jal_cpi", cyc, 3);
    chk("jal_vec", {act_log[2].pcw, act_log[2].npc, act_log[2].rw, act_log[2].rdst, act_log[2].wds},
        32'b1_10_1_10_10);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, "j");
    chk("j_rw", 32'(act_log[2].rw), 0);

    run_instr(6'h3F, 6'h00, 1'b0, 1, 0, "bad_op");
    chk("bad_op_ill", 32'(act_log[1].ill), 1);
    chk("bad_op_cpi", cyc, 3);
    chk("bad_op_writes", rw_cnt + mw_cnt, 0);
    run_instr(6'h00, 6'h21, 1'b0, 0, 0, "bad_fn");
    chk("bad_fn_ill", 32'(act_log[2].ill), 1);

    // Abort an in-flight store with reset while MemWrite is high
    ifc.Op = OP_SW; ifc.Funct = 6'h00; ifc.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 ifc.mem_ready = 1'b0;
    @(negedge clk);
    a = sample();
    chk("memwr_state", 32'(a.st), 32'(S_MEMWR));
    chk("memwr_we", 32'(a.mwr), 1);
    #2 rstn = 1'b0;
    #1 a = sample();
    chk("abort_mw", 32'(a.mwr), 0);
    chk("abort_st", 32'(a.st), 32'(S_FETCH));
    chk("abort_mr", 32'(a.mrd), 1);
    ifc.mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("abort_pcw", 32'(ifc.PCWrite), 0);
    rstn = 1'b1;

    for (int i = 0; i < 300; i++) begin
      run_instr(ops[$urandom_range(0, 10)], fns[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
